// File: rtl/freq_meter.sv
// freq_meter: measures the divider's output clock (div_in) by counting its
// rising edges over a fixed window of GATE_CYCLES system clocks.
//
// Flow: IDLE -> ARM (1 cycle) -> GATE (GATE_CYCLES cycles) -> DONE (1 cycle).
// The result (count/overflow) is registered on the GATE->DONE edge and is
// qualified by a one-cycle count_valid strobe during DONE. With continuous=1
// the FSM loops DONE->ARM, giving one result every GATE_CYCLES+2 clocks.
//
// Optional feature, macro FREQ_METER_RANGE_CHECK_EN: adds exp_min/exp_max
// inputs and an in_range output that flags whether the latest result lies
// inside [exp_min, exp_max] without overflow.
//
// Reset is asynchronous and active-high on port 'reset'.

module freq_meter #(
  parameter int GATE_CYCLES = 1000,  // gate window length in clk cycles (>= 2)
  parameter int GATE_W      = 16,    // gate counter width, holds GATE_CYCLES-1
  parameter int CNT_W       = 12,    // edge counter / result width
  parameter int SYNC_STAGES = 2      // synchronizer depth on div_in (>= 2)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             div_in,
  input  logic             start,
  input  logic             continuous,
`ifdef FREQ_METER_RANGE_CHECK_EN
  input  logic [CNT_W-1:0] exp_min,
  input  logic [CNT_W-1:0] exp_max,
  output logic             in_range,
`endif
  output logic [CNT_W-1:0] count,
  output logic             count_valid,
  output logic             busy,
  output logic             overflow
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ARM  = 2'd1,
    S_GATE = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [GATE_W-1:0] GATE_LOAD = GATE_W'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

  state_t             state;
  logic [SYNC_STAGES-1:0] sync_q;
  logic               hist_q;
  logic               rise;
  logic [GATE_W-1:0]  gate_cnt;
  logic [CNT_W-1:0]   edge_cnt;
  logic               ovf_q;
  logic [CNT_W-1:0]   edge_next;
  logic               ovf_next;
`ifdef FREQ_METER_RANGE_CHECK_EN
  logic               range_next;
`endif

  // Synchronize div_in into clk and keep one history flop for edge detection.
  // NOTE: non-blocking assignments let each stage sample the previous stage's
  // old value, which is what makes this a shift register rather than a wire.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], div_in};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise = sync_q[SYNC_STAGES-1] & ~hist_q;

  // Next edge count with saturation; an increment attempted at max flags overflow.
  // NOTE: every output of this block gets a default first so no path through it
  // can leave a value unassigned and infer a latch.
  always_comb begin
    edge_next = edge_cnt;
    ovf_next  = ovf_q;
    if (rise) begin
      if (edge_cnt == CNT_MAX) begin
        ovf_next = 1'b1;
      end else begin
        edge_next = edge_cnt + 1'b1;
      end
    end
  end

`ifdef FREQ_METER_RANGE_CHECK_EN
  // Range comparison on the value about to be latched as the result; an
  // inverted window (exp_min > exp_max) can never be satisfied.
  always_comb begin
    range_next = 1'b0;
    if (!ovf_next && (exp_min <= edge_next) && (edge_next <= exp_max)) begin
      range_next = 1'b1;
    end
  end
`endif

  // Measurement FSM with registered outputs; busy tracks the next state so it
  // is high exactly while the FSM sits in ARM, GATE or DONE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      gate_cnt    <= '0;
      edge_cnt    <= '0;
      ovf_q       <= 1'b0;
      count       <= '0;
      count_valid <= 1'b0;
      busy        <= 1'b0;
      overflow    <= 1'b0;
`ifdef FREQ_METER_RANGE_CHECK_EN
      in_range    <= 1'b0;
`endif
    end else begin
      count_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start || continuous) begin
            state <= S_ARM;
            busy  <= 1'b1;
          end
        end

        S_ARM: begin
          edge_cnt <= '0;
          gate_cnt <= GATE_LOAD;
          ovf_q    <= 1'b0;
          state    <= S_GATE;
        end

        S_GATE: begin
          edge_cnt <= edge_next;
          ovf_q    <= ovf_next;
          if (gate_cnt == '0) begin
            // Last gate cycle: its own rise is already folded into edge_next.
            state       <= S_DONE;
            count       <= edge_next;
            overflow    <= ovf_next;
            count_valid <= 1'b1;
`ifdef FREQ_METER_RANGE_CHECK_EN
            in_range    <= range_next;
`endif
          end else begin
            gate_cnt <= gate_cnt - 1'b1;
          end
        end

        S_DONE: begin
          if (continuous) begin
            state <= S_ARM;
          end else begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        end

        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_freq_meter.sv
// Directed testbench for freq_meter. Two instances share all stimulus:
// dut_a (CNT_W=12) for normal counting and dut_b (CNT_W=4) for saturation.
// Both use GATE_CYCLES=100, so a single measurement yields count_valid
// 101 cycles after the ARM cycle and continuous results every 102 cycles.

module tb_freq_meter;

  localparam int GATE = 100;

  logic        clk;
  logic        reset;
  logic        div_in;
  logic        start;
  logic        continuous;
  logic [11:0] count_a;
  logic [3:0]  count_b;
  logic        cv_a, cv_b, busy_a, busy_b, ovf_a, ovf_b;
`ifdef FREQ_METER_RANGE_CHECK_EN
  logic [11:0] exp_min_a, exp_max_a;
  logic [3:0]  exp_min_b, exp_max_b;
  logic        inr_a, inr_b;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // div_in generator: period 0 means hold div_level constant.
  int   div_period = 0;
  logic div_level  = 1'b0;
  int   phase      = 0;

  freq_meter #(.GATE_CYCLES(GATE), .GATE_W(16), .CNT_W(12), .SYNC_STAGES(2)) dut_a (
    .clk(clk), .reset(reset), .div_in(div_in), .start(start), .continuous(continuous),
`ifdef FREQ_METER_RANGE_CHECK_EN
    .exp_min(exp_min_a), .exp_max(exp_max_a), .in_range(inr_a),
`endif
    .count(count_a), .count_valid(cv_a), .busy(busy_a), .overflow(ovf_a)
  );

  freq_meter #(.GATE_CYCLES(GATE), .GATE_W(16), .CNT_W(4), .SYNC_STAGES(2)) dut_b (
    .clk(clk), .reset(reset), .div_in(div_in), .start(start), .continuous(continuous),
`ifdef FREQ_METER_RANGE_CHECK_EN
    .exp_min(exp_min_b), .exp_max(exp_max_b), .in_range(inr_b),
`endif
    .count(count_b), .count_valid(cv_b), .busy(busy_b), .overflow(ovf_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    div_in = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (div_period == 0) begin
        div_in = div_level;
      end else begin
        phase  = (phase + 1) % div_period;
        div_in = (phase < div_period / 2);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Waits up to limit negedges for count_valid on dut_a; n = cycles waited or -1.
  task automatic wait_valid(input int limit, output int n);
    n = -1;
    for (int i = 1; i <= limit; i++) begin
      @(negedge clk);
      if (cv_a) begin
        n = i;
        break;
      end
    end
  endtask

  // One single-shot measurement: start pulse, latency check, lands in DONE.
  task automatic run_single(input string tag);
    int n;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({tag, "_busy_arm"}, 32'(busy_a), 32'd1);
    wait_valid(300, n);
    check({tag, "_latency"}, 32'(n), 32'(GATE + 1));
    check({tag, "_valid_b"}, 32'(cv_b), 32'd1);
  endtask

  initial begin
    int n;
    int seen;
    reset      = 1'b1;
    start      = 1'b0;
    continuous = 1'b0;
`ifdef FREQ_METER_RANGE_CHECK_EN
    exp_min_a = 12'd9;  exp_max_a = 12'd11;
    exp_min_b = 4'd9;   exp_max_b = 4'd11;
`endif

    // Reset state, then idle with no start.
    #1;
    check("rst_count", 32'(count_a), 32'd0);
    check("rst_valid", 32'(cv_a), 32'd0);
    check("rst_busy", 32'(busy_a), 32'd0);
    check("rst_ovf", 32'(ovf_a), 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (busy_a || cv_a) seen++;
    end
    check("idle_no_activity", 32'(seen), 32'd0);

    // Single measurement, div_in period 10 -> 10 edges.
    div_period = 10;
    repeat (10) @(negedge clk);
    run_single("p10");
    check("p10_count", 32'(count_a), 32'd10);
    check("p10_ovf", 32'(ovf_a), 32'd0);
    check("p10_count_b", 32'(count_b), 32'd10);
`ifdef FREQ_METER_RANGE_CHECK_EN
    check("p10_in_range", 32'(inr_a), 32'd1);
    check("p10_in_range_b", 32'(inr_b), 32'd1);
`endif
    @(negedge clk);
    check("p10_valid_single", 32'(cv_a), 32'd0);
    check("p10_busy_low", 32'(busy_a), 32'd0);
    check("p10_count_hold", 32'(count_a), 32'd10);
`ifdef FREQ_METER_RANGE_CHECK_EN
    check("p10_in_range_hold", 32'(inr_a), 32'd1);
`endif

    // Asynchronous reset mid-cycle clears outputs immediately.
    #2 reset = 1'b1;
    #1;
    check("async_count", 32'(count_a), 32'd0);
    check("async_busy", 32'(busy_a), 32'd0);
    check("async_valid", 32'(cv_a), 32'd0);
`ifdef FREQ_METER_RANGE_CHECK_EN
    check("async_in_range", 32'(inr_a), 32'd0);
`endif
    @(negedge clk);
    reset = 1'b0;

    // Continuous mode, period 4 -> 25 per window; dut_b saturates at 15.
    div_period = 4;
`ifdef FREQ_METER_RANGE_CHECK_EN
    exp_min_b = 4'd0; exp_max_b = 4'd15;
`endif
    repeat (10) @(negedge clk);
    continuous = 1'b1;
    wait_valid(300, n);
    check("cont_first_seen", 32'(n > 0), 32'd1);
    check("cont_first_count", 32'(count_a), 32'd25);
    // Second window: stray start pulse during GATE must not disturb period.
    n = -1;
    for (int i = 1; i <= 300; i++) begin
      @(negedge clk);
      start = (i == 40);
      if (cv_a) begin
        n = i;
        break;
      end
    end
    start = 1'b0;
    check("cont_period", 32'(n), 32'(GATE + 2));
    check("cont_count", 32'(count_a), 32'd25);
    check("cont_ovf", 32'(ovf_a), 32'd0);
    check("sat_count_b", 32'(count_b), 32'd15);
    check("sat_ovf_b", 32'(ovf_b), 32'd1);
`ifdef FREQ_METER_RANGE_CHECK_EN
    check("cont_in_range", 32'(inr_a), 32'd0);
    check("sat_in_range_b", 32'(inr_b), 32'd0);
`endif
    // Third window: drop continuous mid-measurement; it finishes, then idles.
    n = -1;
    for (int i = 1; i <= 300; i++) begin
      @(negedge clk);
      if (i == 40) continuous = 1'b0;
      if (cv_a) begin
        n = i;
        break;
      end
    end
    check("cont_drop_period", 32'(n), 32'(GATE + 2));
    check("cont_drop_count", 32'(count_a), 32'd25);
    @(negedge clk);
    check("cont_drop_busy", 32'(busy_a), 32'd0);
    seen = 0;
    for (int i = 0; i < 150; i++) begin
      @(negedge clk);
      if (cv_a || busy_a) seen++;
    end
    check("cont_drop_idle", 32'(seen), 32'd0);

    // Constant div_in: zero edges, overflow cleared on dut_b.
    div_period = 0;
    div_level  = 1'b0;
    repeat (10) @(negedge clk);
    run_single("const");
    check("const_count", 32'(count_a), 32'd0);
    check("const_ovf", 32'(ovf_a), 32'd0);
    check("const_count_b", 32'(count_b), 32'd0);
    check("const_ovf_b", 32'(ovf_b), 32'd0);

    // Period 8 -> 12 or 13 edges depending on phase.
    div_period = 8;
`ifdef FREQ_METER_RANGE_CHECK_EN
    exp_min_a = 12'd9; exp_max_a = 12'd11;
`endif
    repeat (10) @(negedge clk);
    run_single("p8");
    check("p8_count", 32'((count_a == 12'd12) || (count_a == 12'd13)), 32'd1);
`ifdef FREQ_METER_RANGE_CHECK_EN
    check("p8_in_range", 32'(inr_a), 32'd0);
    exp_min_a = 12'd12; exp_max_a = 12'd5;
    repeat (5) @(negedge clk);
    run_single("inv");
    check("inv_in_range", 32'(inr_a), 32'd0);
`endif

    // Reset mid-GATE aborts the measurement.
    repeat (5) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (51) @(negedge clk);
    check("abort_in_gate", 32'(busy_a), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("abort_count", 32'(count_a), 32'd0);
    check("abort_busy", 32'(busy_a), 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    seen = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (cv_a || cv_b) seen++;
    end
    check("abort_no_valid", 32'(seen), 32'd0);
    check("abort_count_stays", 32'(count_a), 32'd0);
    check("abort_idle", 32'(busy_a), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
